// File: rtl/video_fx_ctrl.sv
// ----------------------------------------------------------------------------
// video_fx_ctrl
//
// Frame-synchronous colour effect controller. Game events (brick hit, ball
// missed, level won) are latched as pending flags and arbitrated once per
// frame at frame_start. The winning event starts a timed colour effect on the
// background/border colour registers. Because those registers only change at
// frame_start (or on fx_clear), an effect never tears mid-frame.
//
// Ports:
//   clk          pixel clock
//   rst          asynchronous, active-high reset
//   frame_start  one-cycle pulse per frame, issued in vertical blanking
//   evt_brick    one-cycle pulse: brick destroyed
//   evt_miss     one-cycle pulse: ball lost
//   evt_win      one-cycle pulse: level cleared
//   fx_clear     synchronous abort back to idle (allowed mid-frame)
//   background   registered background colour (RRGGBB)
//   border       registered border colour (RRGGBB)
//   fx_active    high while any effect runs
//   fx_id        current effect: 0 idle, 1 brick, 2 miss, 3 win
// ----------------------------------------------------------------------------
module video_fx_ctrl #(
    parameter logic [5:0] BASE_BG      = 6'b000000,
    parameter logic [5:0] BASE_BORDER  = 6'b010101,
    parameter logic [5:0] BRICK_COLOR  = 6'b111111,
    parameter logic [5:0] MISS_COLOR   = 6'b110000,
    parameter int unsigned BRICK_FRAMES = 4,
    parameter int unsigned MISS_FRAMES  = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_start,
    input  logic       evt_brick,
    input  logic       evt_miss,
    input  logic       evt_win,
    input  logic       fx_clear,
    output logic [5:0] background,
    output logic [5:0] border,
    output logic       fx_active,
    output logic [1:0] fx_id
);

    // Encoding matches the fx_id values so the two stay trivially consistent.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BRICK = 2'd1,
        ST_MISS  = 2'd2,
        ST_WIN   = 2'd3
    } state_e;

    // Counters hold "frames remaining after this one", so entry loads N-1.
    localparam logic [4:0] BRICK_LAST = 5'(BRICK_FRAMES - 1);
    localparam logic [4:0] MISS_LAST  = 5'(MISS_FRAMES - 1);

    state_e     state_q;
    logic [4:0] cnt_q;
    logic [5:0] bg_q;
    logic [5:0] border_q;
    logic       active_q;
    logic [1:0] id_q;
    logic       strobe_on_q;   // miss strobe phase: 1 = MISS_COLOR shown
    logic       pend_brick_q;
    logic       pend_miss_q;
    logic       pend_win_q;

    // An event pulsing on the frame_start cycle takes part in that decision.
    logic brick_now;
    logic miss_now;
    logic win_now;

    assign brick_now = pend_brick_q | evt_brick;
    assign miss_now  = pend_miss_q  | evt_miss;
    assign win_now   = pend_win_q   | evt_win;

    // NOTE: all state in this block is assigned with non-blocking (<=) so every
    // register samples pre-edge values and the arbitration below reads the
    // current state, not a partially updated one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bg_q         <= BASE_BG;
            border_q     <= BASE_BORDER;
            active_q     <= 1'b0;
            id_q         <= 2'd0;
            strobe_on_q  <= 1'b0;
            pend_brick_q <= 1'b0;
            pend_miss_q  <= 1'b0;
            pend_win_q   <= 1'b0;
        end else if (fx_clear) begin
            // Abort outranks events and frame_start; the only mid-frame change.
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            bg_q         <= BASE_BG;
            border_q     <= BASE_BORDER;
            active_q     <= 1'b0;
            id_q         <= 2'd0;
            strobe_on_q  <= 1'b0;
            pend_brick_q <= 1'b0;
            pend_miss_q  <= 1'b0;
            pend_win_q   <= 1'b0;
        end else if (frame_start) begin
            // Events are consumed or dropped here, never carried to the next frame.
            pend_brick_q <= 1'b0;
            pend_miss_q  <= 1'b0;
            pend_win_q   <= 1'b0;

            if (win_now && state_q != ST_WIN) begin
                state_q  <= ST_WIN;
                id_q     <= 2'd3;
                active_q <= 1'b1;
                cnt_q    <= '0;
                bg_q     <= BASE_BG;
                border_q <= BASE_BORDER + 6'd1;
            end else if (miss_now && state_q != ST_WIN) begin
                state_q     <= ST_MISS;
                id_q        <= 2'd2;
                active_q    <= 1'b1;
                cnt_q       <= MISS_LAST;
                bg_q        <= MISS_COLOR;
                border_q    <= BASE_BORDER;
                strobe_on_q <= 1'b1;
            end else if (brick_now && (state_q == ST_IDLE || state_q == ST_BRICK)) begin
                state_q  <= ST_BRICK;
                id_q     <= 2'd1;
                active_q <= 1'b1;
                cnt_q    <= BRICK_LAST;
                bg_q     <= BASE_BG;
                border_q <= BRICK_COLOR;
            end else begin
                case (state_q)
                    ST_BRICK, ST_MISS: begin
                        if (cnt_q == '0) begin
                            state_q     <= ST_IDLE;
                            id_q        <= 2'd0;
                            active_q    <= 1'b0;
                            bg_q        <= BASE_BG;
                            border_q    <= BASE_BORDER;
                            strobe_on_q <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 5'd1;
                            if (state_q == ST_MISS) begin
                                // Phase bit rather than colour compare, so the
                                // strobe still alternates if MISS_COLOR == BASE_BG.
                                strobe_on_q <= ~strobe_on_q;
                                bg_q        <= strobe_on_q ? BASE_BG : MISS_COLOR;
                            end
                        end
                    end
                    ST_WIN: begin
                        border_q <= border_q + 6'd1;   // wraps 63 -> 0
                    end
                    default: begin
                        bg_q     <= BASE_BG;
                        border_q <= BASE_BORDER;
                    end
                endcase
            end
        end else begin
            pend_brick_q <= brick_now;
            pend_miss_q  <= miss_now;
            pend_win_q   <= win_now;
        end
    end

    assign background = bg_q;
    assign border     = border_q;
    assign fx_active  = active_q;
    assign fx_id      = id_q;

endmodule

// File: tb/tb_video_fx_ctrl.sv
// ----------------------------------------------------------------------------
// tb_video_fx_ctrl
//
// Directed bench for video_fx_ctrl: a table of single-cycle vectors with
// hand-computed expected outputs, plus hand-written multi-frame sequences for
// the miss strobe, the win colour cycle and asynchronous reset mid-effect.
// ----------------------------------------------------------------------------
module tb_video_fx_ctrl;

    localparam logic [5:0] C_BG     = 6'b000000;
    localparam logic [5:0] C_BORDER = 6'b010101;
    localparam logic [5:0] C_BRICK  = 6'b111111;
    localparam logic [5:0] C_MISS   = 6'b110000;

    logic       clk;
    logic       rst;
    logic       frame_start;
    logic       evt_brick;
    logic       evt_miss;
    logic       evt_win;
    logic       fx_clear;
    logic [5:0] background;
    logic [5:0] border;
    logic       fx_active;
    logic [1:0] fx_id;

    int n_checks = 0;
    int n_errors = 0;

    video_fx_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .evt_brick   (evt_brick),
        .evt_miss    (evt_miss),
        .evt_win     (evt_win),
        .fx_clear    (fx_clear),
        .background  (background),
        .border      (border),
        .fx_active   (fx_active),
        .fx_id       (fx_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       fs;
        logic       brick;
        logic       miss;
        logic       win;
        logic       clr;
        logic [5:0] exp_bg;
        logic [5:0] exp_border;
        logic       exp_active;
        logic [1:0] exp_id;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_outs(input string name, input logic [5:0] bg, input logic [5:0] bd,
                              input logic act, input logic [1:0] id);
        check({name, ".background"}, {2'b0, background}, {2'b0, bg});
        check({name, ".border"},     {2'b0, border},     {2'b0, bd});
        check({name, ".fx_active"},  {7'b0, fx_active},  {7'b0, act});
        check({name, ".fx_id"},      {6'b0, fx_id},      {6'b0, id});
    endtask

    // Drive one cycle of inputs, let the edge happen, leave inputs idle after.
    task automatic tick(input logic fs, input logic b, input logic m,
                        input logic w, input logic c);
        @(negedge clk);
        frame_start = fs;
        evt_brick   = b;
        evt_miss    = m;
        evt_win     = w;
        fx_clear    = c;
        @(posedge clk);
        #1;
        frame_start = 1'b0;
        evt_brick   = 1'b0;
        evt_miss    = 1'b0;
        evt_win     = 1'b0;
        fx_clear    = 1'b0;
    endtask

    function automatic vec_t mk(input string n, input logic fs, input logic b, input logic m,
                                input logic w, input logic c, input logic [5:0] bg,
                                input logic [5:0] bd, input logic act, input logic [1:0] id);
        vec_t v;
        v.name = n; v.fs = fs; v.brick = b; v.miss = m; v.win = w; v.clr = c;
        v.exp_bg = bg; v.exp_border = bd; v.exp_active = act; v.exp_id = id;
        return v;
    endfunction

    // Miss strobe: pulse, then 16 effect frames alternating, then idle. With
    // add_brick the coincident brick must be dropped (no flash afterwards).
    task automatic miss_seq(input string tag, input logic add_brick);
        logic [5:0] bg;
        tick(1'b0, add_brick, 1'b1, 1'b0, 1'b0);
        check_outs({tag, ".pulse"}, C_BG, C_BORDER, 1'b0, 2'd0);
        for (int k = 1; k <= 17; k++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (k <= 16) begin
                bg = (k % 2 == 1) ? C_MISS : C_BG;
                check_outs($sformatf("%s.f%0d", tag, k), bg, C_BORDER, 1'b1, 2'd2);
            end else begin
                check_outs($sformatf("%s.f%0d", tag, k), C_BG, C_BORDER, 1'b0, 2'd0);
            end
        end
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_outs({tag, ".after"}, C_BG, C_BORDER, 1'b0, 2'd0);
    endtask

    initial begin
        logic [5:0] exp_bd;

        rst = 1'b1;
        frame_start = 1'b0;
        evt_brick = 1'b0;
        evt_miss = 1'b0;
        evt_win = 1'b0;
        fx_clear = 1'b0;

        // Brick flash, 4 frames.
        vecs.push_back(mk("t1.pulse", 0,1,0,0,0, C_BG, C_BORDER, 0, 0));
        vecs.push_back(mk("t1.nofs",  0,0,0,0,0, C_BG, C_BORDER, 0, 0));
        vecs.push_back(mk("t1.f1",    1,0,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("t1.mid",   0,0,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("t1.f2",    1,0,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("t1.f3",    1,0,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("t1.f4",    1,0,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("t1.f5",    1,0,0,0,0, C_BG, C_BORDER, 0, 0));
        // Expiry coincident with a new miss: straight into MISS.
        vecs.push_back(mk("t5.f1",    1,1,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("t5.f2",    1,0,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("t5.f3",    1,0,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("t5.f4",    1,0,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("t5.miss",  1,0,1,0,0, C_MISS, C_BORDER, 1, 2));
        vecs.push_back(mk("t5.f2m",   1,0,0,0,0, C_BG, C_BORDER, 1, 2));
        // fx_clear mid-frame, then fx_clear beating frame_start and events.
        vecs.push_back(mk("clr.mid",  0,0,0,0,1, C_BG, C_BORDER, 0, 0));
        vecs.push_back(mk("clr.pend", 0,1,0,0,0, C_BG, C_BORDER, 0, 0));
        vecs.push_back(mk("clr.fs",   1,0,1,0,1, C_BG, C_BORDER, 0, 0));
        vecs.push_back(mk("clr.drop", 1,0,0,0,0, C_BG, C_BORDER, 0, 0));
        // Brick restart while in BRICK reloads the count.
        vecs.push_back(mk("rs.f1",    1,1,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("rs.f2",    1,0,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("rs.re",    1,1,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("rs.r2",    1,0,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("rs.r3",    1,0,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("rs.r4",    1,0,0,0,0, C_BG, C_BRICK,  1, 1));
        vecs.push_back(mk("rs.end",   1,0,0,0,0, C_BG, C_BORDER, 0, 0));

        repeat (2) @(negedge clk);
        check_outs("reset", C_BG, C_BORDER, 1'b0, 2'd0);
        rst = 1'b0;

        foreach (vecs[i]) begin
            tick(vecs[i].fs, vecs[i].brick, vecs[i].miss, vecs[i].win, vecs[i].clr);
            check_outs(vecs[i].name, vecs[i].exp_bg, vecs[i].exp_border,
                       vecs[i].exp_active, vecs[i].exp_id);
        end

        miss_seq("t2", 1'b0);
        miss_seq("t3", 1'b1);

        // Win colour cycle: no timeout, wraps, ignores later events.
        tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        exp_bd = C_BORDER;
        for (int k = 1; k <= 70; k++) begin
            if (k == 35) tick(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
            tick(1'b1, (k == 50), 1'b0, 1'b0, 1'b0);
            exp_bd = exp_bd + 6'd1;
            check_outs($sformatf("t4.f%0d", k), C_BG, exp_bd, 1'b1, 2'd3);
        end
        tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check_outs("t4.clear", C_BG, C_BORDER, 1'b0, 2'd0);

        // Asynchronous reset mid-miss, then a normal brick flash.
        tick(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        check_outs("t6.inmiss", C_MISS, C_BORDER, 1'b1, 2'd2);
        #1 rst = 1'b1;
        #1 check_outs("t6.async", C_BG, C_BORDER, 1'b0, 2'd0);
        @(negedge clk);
        rst = 1'b0;
        tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            check_outs($sformatf("t6.f%0d", k), C_BG, (k <= 4) ? C_BRICK : C_BORDER,
                       (k <= 4), (k <= 4) ? 2'd1 : 2'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
